mdu_ctrl: RTL and testbench

//  Sequencer for the multiply/divide resource (FUNC_MULTDIV class) in the E stage.
//  - Accepts one MD op per start pulse and owns the HI/LO registers.
//  - Models fixed mult/div latency with a down-counter and drives busy.
//  - Generates the D-stage stall for MD-class instructions; supports a synchronous cancel.

---
 rtl/mdu_ctrl_pkg.sv | 46 ++++
 rtl/mdu_arith.sv | 78 +++++++
 rtl/mdu_ctrl.sv | 148 ++++++++++++++
 tb/tb_mdu_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_ctrl_pkg.sv
// Shared definitions for the multiply/divide sequencer: op encodings, FSM states, op decode helpers.
// MDU_MADD_EN enables the signed MADD/MSUB accumulate ops (codes 9/10); otherwise they decode as NONE.
package mdu_ctrl_pkg;

  localparam int unsigned WIDTH_MDOP = 4;

  localparam logic [WIDTH_MDOP-1:0] MD_NONE  = 4'd0;
  localparam logic [WIDTH_MDOP-1:0] MD_MULT  = 4'd1;
  localparam logic [WIDTH_MDOP-1:0] MD_MULTU = 4'd2;
  localparam logic [WIDTH_MDOP-1:0] MD_DIV   = 4'd3;
  localparam logic [WIDTH_MDOP-1:0] MD_DIVU  = 4'd4;
  localparam logic [WIDTH_MDOP-1:0] MD_MFHI  = 4'd5;
  localparam logic [WIDTH_MDOP-1:0] MD_MFLO  = 4'd6;
  localparam logic [WIDTH_MDOP-1:0] MD_MTHI  = 4'd7;
  localparam logic [WIDTH_MDOP-1:0] MD_MTLO  = 4'd8;
  localparam logic [WIDTH_MDOP-1:0] MD_MADD  = 4'd9;
  localparam logic [WIDTH_MDOP-1:0] MD_MSUB  = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } mdu_state_e;

  function automatic logic md_is_mul(input logic [WIDTH_MDOP-1:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

  function automatic logic md_is_div(input logic [WIDTH_MDOP-1:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_acc(input logic [WIDTH_MDOP-1:0] op);
`ifdef MDU_MADD_EN
    return (op == MD_MADD) || (op == MD_MSUB);
`else
    return (op == MD_NONE) && (op != MD_NONE);
`endif
  endfunction

  // Ops that occupy the unit for multiple cycles and therefore stall D-stage MD ops.
  function automatic logic md_is_long(input logic [WIDTH_MDOP-1:0] op);
    return md_is_mul(op) || md_is_div(op) || md_is_acc(op);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational multiply / divide datapath; adds the HI:LO accumulate adder when MDU_MADD_EN is defined.
module mdu_arith
  import mdu_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH_MDOP-1:0] i_op,
  input  logic [WIDTH-1:0]      i_rs_val,
  input  logic [WIDTH-1:0]      i_rt_val,
`ifdef MDU_MADD_EN
  input  logic [WIDTH-1:0]      i_acc_hi,
  input  logic [WIDTH-1:0]      i_acc_lo,
`endif
  output logic [WIDTH-1:0]      o_res_hi,
  output logic [WIDTH-1:0]      o_res_lo,
  output logic                  o_res_vld
);

  localparam int unsigned W2 = 2 * WIDTH;

  logic            w_sgn;
  logic [W2-1:0]   w_ext_rs;
  logic [W2-1:0]   w_ext_rt;
  logic [W2-1:0]   w_prod;
  logic            w_rs_neg;
  logic            w_rt_neg;
  logic [WIDTH-1:0] w_rs_mag;
  logic [WIDTH-1:0] w_rt_mag;
  logic [WIDTH-1:0] w_quo_mag;
  logic [WIDTH-1:0] w_rem_mag;
  logic [WIDTH-1:0] w_quo;
  logic [WIDTH-1:0] w_rem;

  assign w_sgn = (i_op == MD_MULT) || (i_op == MD_DIV) || md_is_acc(i_op);

  // Sign/zero extension to 2*WIDTH makes the low 2*WIDTH product bits correct for both signednesses.
  assign w_ext_rs = w_sgn ? {{WIDTH{i_rs_val[WIDTH-1]}}, i_rs_val} : {{WIDTH{1'b0}}, i_rs_val};
  assign w_ext_rt = w_sgn ? {{WIDTH{i_rt_val[WIDTH-1]}}, i_rt_val} : {{WIDTH{1'b0}}, i_rt_val};
  assign w_prod   = w_ext_rs * w_ext_rt;

  // Signed divide on magnitudes: quotient truncates toward zero, remainder follows the dividend.
  assign w_rs_neg  = w_sgn & i_rs_val[WIDTH-1];
  assign w_rt_neg  = w_sgn & i_rt_val[WIDTH-1];
  assign w_rs_mag  = w_rs_neg ? (~i_rs_val + WIDTH'(1)) : i_rs_val;
  assign w_rt_mag  = w_rt_neg ? (~i_rt_val + WIDTH'(1)) : i_rt_val;
  assign w_quo_mag = w_rs_mag / w_rt_mag;
  assign w_rem_mag = w_rs_mag % w_rt_mag;
  assign w_quo     = (w_rs_neg ^ w_rt_neg) ? (~w_quo_mag + WIDTH'(1)) : w_quo_mag;
  assign w_rem     = w_rs_neg ? (~w_rem_mag + WIDTH'(1)) : w_rem_mag;

`ifdef MDU_MADD_EN
  logic [W2-1:0] w_acc;
  logic [W2-1:0] w_sum;
  assign w_acc = {i_acc_hi, i_acc_lo};
  assign w_sum = (i_op == MD_MSUB) ? (w_acc - w_prod) : (w_acc + w_prod);
`endif

  always_comb begin
    o_res_hi  = '0;
    o_res_lo  = '0;
    o_res_vld = 1'b0;
    if (md_is_mul(i_op)) begin
      {o_res_hi, o_res_lo} = w_prod;
      o_res_vld            = 1'b1;
    end else if (md_is_div(i_op)) begin
      o_res_hi  = w_rem;
      o_res_lo  = w_quo;
      o_res_vld = (i_rt_val != '0);
    end
`ifdef MDU_MADD_EN
    else if (md_is_acc(i_op)) begin
      {o_res_hi, o_res_lo} = w_sum;
      o_res_vld            = 1'b1;
    end
`endif
  end

endmodule

// File: rtl/mdu_ctrl.sv
// E-stage multiply/divide sequencer: owns HI/LO, models fixed op latency, drives busy and the D-stall.
// MDU_MADD_EN adds MADD/MSUB taking MUL_CYCLES+1 busy cycles.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [WIDTH_MDOP-1:0] op,
  input  logic [WIDTH-1:0]      rs_val,
  input  logic [WIDTH-1:0]      rt_val,
  input  logic                  cancel,
  input  logic                  d_md,
  output logic                  busy,
  output logic                  stall,
  output logic [WIDTH-1:0]      rd_data,
  output logic [WIDTH-1:0]      hi,
  output logic [WIDTH-1:0]      lo
);

  localparam int unsigned MAX_CYC = ((MUL_CYCLES + 1) > DIV_CYCLES) ? (MUL_CYCLES + 1) : DIV_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] CNT_MUL     = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MUL_ACC = CNT_W'(MUL_CYCLES);
  localparam logic [CNT_W-1:0] CNT_DIV     = CNT_W'(DIV_CYCLES - 1);

  mdu_state_e       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_hi, w_hi_nxt;
  logic [WIDTH-1:0] r_lo, w_lo_nxt;
  logic [WIDTH-1:0] r_pend_hi, w_pend_hi_nxt;
  logic [WIDTH-1:0] r_pend_lo, w_pend_lo_nxt;
  logic             r_pend_wr, w_pend_wr_nxt;

  logic [WIDTH-1:0] w_res_hi;
  logic [WIDTH-1:0] w_res_lo;
  logic             w_res_vld;

  mdu_arith #(.WIDTH(WIDTH)) u_arith (
    .i_op      (op),
    .i_rs_val  (rs_val),
    .i_rt_val  (rt_val),
`ifdef MDU_MADD_EN
    .i_acc_hi  (r_hi),
    .i_acc_lo  (r_lo),
`endif
    .o_res_hi  (w_res_hi),
    .o_res_lo  (w_res_lo),
    .o_res_vld (w_res_vld)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_pend_hi <= '0;
      r_pend_lo <= '0;
      r_pend_wr <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_hi      <= w_hi_nxt;
      r_lo      <= w_lo_nxt;
      r_pend_hi <= w_pend_hi_nxt;
      r_pend_lo <= w_pend_lo_nxt;
      r_pend_wr <= w_pend_wr_nxt;
    end
  end

  // Result is computed at the start edge and parked; the counter only models latency.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_hi_nxt      = r_hi;
    w_lo_nxt      = r_lo;
    w_pend_hi_nxt = r_pend_hi;
    w_pend_lo_nxt = r_pend_lo;
    w_pend_wr_nxt = r_pend_wr;
    case (r_state)
      ST_IDLE: begin
        if (start && !cancel) begin
          if (md_is_mul(op) || md_is_acc(op)) begin
            w_state_nxt   = ST_MUL;
            w_cnt_nxt     = md_is_acc(op) ? CNT_MUL_ACC : CNT_MUL;
            w_pend_hi_nxt = w_res_hi;
            w_pend_lo_nxt = w_res_lo;
            w_pend_wr_nxt = w_res_vld;
          end else if (md_is_div(op)) begin
            w_state_nxt   = ST_DIV;
            w_cnt_nxt     = CNT_DIV;
            w_pend_hi_nxt = w_res_hi;
            w_pend_lo_nxt = w_res_lo;
            w_pend_wr_nxt = w_res_vld;
          end else if (op == MD_MTHI) begin
            w_hi_nxt = rs_val;
          end else if (op == MD_MTLO) begin
            w_lo_nxt = rs_val;
          end
        end
      end
      ST_MUL, ST_DIV: begin
        if (cancel) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == '0) begin
          w_state_nxt = ST_IDLE;
          if (r_pend_wr) begin
            w_hi_nxt = r_pend_hi;
            w_lo_nxt = r_pend_lo;
          end
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    rd_data = '0;
    if (op == MD_MFHI) begin
      rd_data = r_hi;
    end else if (op == MD_MFLO) begin
      rd_data = r_lo;
    end
  end

  assign busy  = (r_state != ST_IDLE);
  assign stall = d_md & (busy | (start & md_is_long(op)));
  assign hi    = r_hi;
  assign lo    = r_lo;

`ifndef SYNTHESIS
  a_no_start_while_busy : assert property (@(posedge clk) disable iff (!reset_n) !(start && busy))
    else $error("mdu_ctrl: start issued while busy");
`endif

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: directed MD ops push expected {cycles, hi, lo}; a monitor checks at busy fall.
module tb_mdu_ctrl;
  import mdu_ctrl_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [3:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        cancel;
  logic        d_md;
  logic        busy;
  logic        stall;
  logic [31:0] rd_data;
  logic [31:0] hi;
  logic [31:0] lo;

  mdu_ctrl #(.WIDTH(32), .MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .op      (op),
    .rs_val  (rs_val),
    .rt_val  (rt_val),
    .cancel  (cancel),
    .d_md    (d_md),
    .busy    (busy),
    .stall   (stall),
    .rd_data (rd_data),
    .hi      (hi),
    .lo      (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  int          cyc_q[$];
  logic [31:0] hi_q[$];
  logic [31:0] lo_q[$];
  bit          stl_q[$];
  string       nm_q[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic push(input string nm, input int cyc, input logic [31:0] h, input logic [31:0] l,
                      input bit stl);
    nm_q.push_back(nm);
    cyc_q.push_back(cyc);
    hi_q.push_back(h);
    lo_q.push_back(l);
    stl_q.push_back(stl);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    start  = 1'b1;
    op     = o;
    rs_val = a;
    rt_val = b;
    tick();
    start  = 1'b0;
    op     = MD_NONE;
  endtask

  task automatic wait_idle(input string nm);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (!busy) done = 1'b1;
    end
    if (!done) check({nm, "_timeout"}, 32'd0, 32'd1);
    tick();
  endtask

  // Monitor: counts busy cycles and compares HI/LO against the scoreboard when busy falls.
  initial begin : monitor
    int    bcnt;
    logic  prev;
    int    c;
    logic [31:0] eh, el;
    bit    s;
    string nm;
    bcnt = 0;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (busy) begin
        bcnt++;
        if (stl_q.size() > 0 && stl_q[0]) check({nm_q[0], "_stall_busy"}, 32'(stall), 32'd1);
      end else if (prev) begin
        if (cyc_q.size() == 0) begin
          check("unexpected_busy_fall", 32'd1, 32'd0);
        end else begin
          nm = nm_q.pop_front();
          c  = cyc_q.pop_front();
          eh = hi_q.pop_front();
          el = lo_q.pop_front();
          s  = stl_q.pop_front();
          check({nm, "_cycles"}, 32'(bcnt), 32'(c));
          if (s) check({nm, "_stall_fall"}, 32'(stall), 32'd0);
          check({nm, "_hi"}, hi, eh);
          check({nm, "_lo"}, lo, el);
        end
        bcnt = 0;
      end
      prev = busy;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    cancel  = 1'b0;
    d_md    = 1'b0;
    op      = MD_NONE;
    rs_val  = '0;
    rt_val  = '0;
    repeat (2) @(posedge clk);
    #1;
    d_md = 1'b1;
    #1;
    check("reset_busy",  32'(busy),  32'd0);
    check("reset_hi",    hi,         32'd0);
    check("reset_lo",    lo,         32'd0);
    check("reset_stall", 32'(stall), 32'd0);
    reset_n = 1'b1;
    tick();

    // MULT with d_md held: stall on start cycle and every busy cycle, drops when busy falls
    push("mult", 5, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1);
    start = 1'b1; op = MD_MULT; rs_val = 32'hFFFF_FFFF; rt_val = 32'd2;
    #1;
    check("stall_start", 32'(stall), 32'd1);
    tick();
    start = 1'b0; op = MD_NONE;
    wait_idle("mult");
    d_md = 1'b0;

    push("multu", 5, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0);
    issue(MD_MULTU, 32'hFFFF_FFFF, 32'd2);
    wait_idle("multu");

    push("div", 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    issue(MD_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_idle("div");

    push("divu_zero", 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    issue(MD_DIVU, 32'd7, 32'd0);
    wait_idle("divu_zero");

    push("div_negdiv", 10, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
    issue(MD_DIV, 32'd7, 32'hFFFF_FFFE);
    wait_idle("div_negdiv");

    issue(MD_MTHI, 32'h0000_1234, 32'd0);
    op = MD_MFHI;
    #1;
    check("mthi_busy", 32'(busy), 32'd0);
    check("mfhi_rd", rd_data, 32'h0000_1234);
    issue(MD_MTLO, 32'h0000_ABCD, 32'd0);
    op = MD_MFLO;
    #1;
    check("mflo_rd", rd_data, 32'h0000_ABCD);
    op = MD_MULT;
    #1;
    check("rd_other_zero", rd_data, 32'd0);
    op = MD_NONE;

    // cancel at busy cycle 3
    push("cancel_mid", 3, 32'h0000_1234, 32'h0000_ABCD, 1'b0);
    issue(MD_MULT, 32'd3, 32'd5);
    repeat (2) tick();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    check("cancel_mid_busy", 32'(busy), 32'd0);
    wait_idle("cancel_mid");

    // cancel together with MTLO in IDLE: write suppressed
    start = 1'b1; op = MD_MTLO; rs_val = 32'h0000_5555; cancel = 1'b1;
    tick();
    start = 1'b0; cancel = 1'b0; op = MD_MFLO;
    #1;
    check("cancel_mtlo_rd", rd_data, 32'h0000_ABCD);
    check("cancel_mtlo_lo", lo, 32'h0000_ABCD);
    op = MD_NONE;

    // cancel on the completion edge wins over the HI/LO write
    push("cancel_done", 5, 32'h0000_1234, 32'h0000_ABCD, 1'b0);
    issue(MD_MULT, 32'd2, 32'd3);
    repeat (4) tick();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    wait_idle("cancel_done");

    d_md = 1'b1; start = 1'b1; op = 4'd13; rs_val = 32'd9; rt_val = 32'd9;
    #1;
    check("badop_stall", 32'(stall), 32'd0);
    tick();
    start = 1'b0; op = MD_NONE; d_md = 1'b0;
    check("badop_busy", 32'(busy), 32'd0);
    check("badop_hi", hi, 32'h0000_1234);

`ifdef MDU_MADD_EN
    issue(MD_MTHI, 32'd0, 32'd0);
    issue(MD_MTLO, 32'd5, 32'd0);
    push("madd", 6, 32'd0, 32'd17, 1'b0);
    issue(MD_MADD, 32'd3, 32'd4);
    wait_idle("madd");
    push("msub", 6, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    issue(MD_MSUB, 32'd1, 32'd20);
    wait_idle("msub");
`else
    issue(MD_MADD, 32'd3, 32'd4);
    check("madd_off_busy", 32'(busy), 32'd0);
    check("madd_off_lo", lo, 32'h0000_ABCD);
`endif

    // async reset at DIV busy cycle 4
    push("div_reset", 3, 32'd0, 32'd0, 1'b0);
    issue(MD_DIV, 32'd100, 32'd7);
    repeat (3) tick();
    reset_n = 1'b0;
    #1;
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_hi", hi, 32'd0);
    check("rst_mid_lo", lo, 32'd0);
    tick();
    reset_n = 1'b1;
    repeat (3) tick();

    check("scoreboard_drained", 32'(cyc_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
